// File: rtl/tug_game_if.sv
// Board-side signal bundle for the tug-of-war sequencer: player/start buttons,
// slow tick and victory animation in; rope display, LEDs and game status out.
interface tug_game_if;
  logic       slowen;
  logic       start;
  logic       btn_l;
  logic       btn_r;
  logic [6:0] victory_led;
  logic [6:0] score;
  logic       wingame;
  logic       game_over;
  logic [6:0] led_out;
  logic [1:0] state;

  modport master (
    output slowen, start, btn_l, btn_r, victory_led,
    input  score, wingame, game_over, led_out, state
  );

  modport slave (
    input  slowen, start, btn_l, btn_r, victory_led,
    output score, wingame, game_over, led_out, state
  );
endinterface

// File: rtl/tug_game_ctrl.sv
// Tug-of-war game sequencer: conditions the buttons into single presses,
// arbitrates moves between players, tracks the rope position and handles the win.
module tug_game_ctrl #(
  parameter int unsigned PRESS_GAP = 4,
  parameter int unsigned WIN_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  tug_game_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WIN  = 2'b10
  } state_t;

  localparam logic [7:0]        GAP_LOAD = 8'(PRESS_GAP - 1);
  localparam logic [7:0]        WIN_LAST = 8'(WIN_TICKS);
  localparam logic signed [2:0] POS_MAX  = 3'sd3;
  localparam logic signed [2:0] POS_MIN  = -3'sd3;

  // Bit order in the conditioning vectors: {btn_r, btn_l, start}
  logic [2:0]        w_raw;
  logic [2:0]        r_sync1, r_sync2, r_prev;
  logic [2:0]        w_press;
  logic              w_press_start, w_press_l, w_press_r;

  state_t            r_state, w_state_next;
  logic signed [2:0] r_pos, w_pos_next, w_pos_step;
  logic [7:0]        r_gap, w_gap_next;
  logic [7:0]        r_win_cnt, w_win_cnt_next;
  logic              r_wingame, w_wingame_next;
  logic [6:0]        w_score;
  logic              w_game_over;

  assign w_raw         = {bus.btn_r, bus.btn_l, bus.start};
  assign w_press       = r_sync2 & ~r_prev;
  assign w_press_start = w_press[0];
  assign w_press_l     = w_press[1];
  assign w_press_r     = w_press[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_state   <= IDLE;
      r_pos     <= '0;
      r_gap     <= '0;
      r_win_cnt <= '0;
      r_wingame <= 1'b0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_state   <= w_state_next;
      r_pos     <= w_pos_next;
      r_gap     <= w_gap_next;
      r_win_cnt <= w_win_cnt_next;
      r_wingame <= w_wingame_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pos_next     = r_pos;
    w_pos_step     = r_pos;
    w_gap_next     = (r_gap != 8'd0) ? r_gap - 8'd1 : r_gap;
    w_win_cnt_next = r_win_cnt;
    w_wingame_next = 1'b0;
    case (r_state)
      IDLE: begin
        w_pos_next = '0;
        if (w_press_start) w_state_next = PLAY;
      end
      PLAY: begin
        // Simultaneous presses cancel each other and leave the gap timer idle
        if ((r_gap == 8'd0) && (w_press_l ^ w_press_r)) begin
          w_pos_step = w_press_r ? r_pos + 3'sd1 : r_pos - 3'sd1;
          w_pos_next = w_pos_step;
          w_gap_next = GAP_LOAD;
          if (w_pos_step == POS_MAX || w_pos_step == POS_MIN) begin
            w_state_next   = WIN;
            w_win_cnt_next = 8'd0;
            w_wingame_next = 1'b1;
          end
        end
      end
      WIN: begin
        if (bus.slowen) begin
          w_win_cnt_next = r_win_cnt + 8'd1;
          if (w_win_cnt_next == WIN_LAST) begin
            w_state_next = IDLE;
            w_pos_next   = '0;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    case (r_pos)
      3'b001:  w_score = 7'b0000100;
      3'b010:  w_score = 7'b0000010;
      3'b011:  w_score = 7'b0000111;
      3'b111:  w_score = 7'b0010000;
      3'b110:  w_score = 7'b0100000;
      3'b101:  w_score = 7'b1110000;
      default: w_score = 7'b0001000;
    endcase
  end

  assign w_game_over   = (r_state == WIN);
  assign bus.score     = w_score;
  assign bus.game_over = w_game_over;
  assign bus.led_out   = w_game_over ? bus.victory_led : w_score;
  assign bus.wingame   = r_wingame;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Bench for tug_game_ctrl: directed scenarios plus a randomized run checked
// against a cycle-indexed behavioural model of the game rules.
module tb_tug_game_ctrl;

  localparam int PRESS_GAP = 4;
  localparam int WIN_TICKS = 3;
  localparam int HIST      = 16384;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  tug_game_if bus ();

  tug_game_ctrl #(.PRESS_GAP(PRESS_GAP), .WIN_TICKS(WIN_TICKS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: input samples recorded per edge; a press is a 0->1 step
  // in the samples two and three edges back, ignoring anything up to a reset.
  bit   hs [HIST];
  bit   hl [HIST];
  bit   hr [HIST];
  int   cyc      = 0;
  int   last_rst = -1;
  int   m_mode   = 0;   // 0 idle, 1 play, 2 win
  int   m_pos    = 0;
  int   m_next_ok = 0;  // first edge at which a move may be accepted
  int   m_wcnt   = 0;
  bit   m_wingame = 1'b0;
  logic [6:0] score_tbl [7] = '{7'b1110000, 7'b0100000, 7'b0010000, 7'b0001000,
                                7'b0000100, 7'b0000010, 7'b0000111};

  function automatic bit seen(int n, int which);
    if (n < 0 || n <= last_rst) return 1'b0;
    case (which)
      0:       return hs[n];
      1:       return hl[n];
      default: return hr[n];
    endcase
  endfunction

  function automatic bit pressed(int which);
    return seen(cyc - 2, which) && !seen(cyc - 3, which);
  endfunction

  always @(posedge clk) begin
    bit ps, pl, pr;
    cyc++;
    hs[cyc] = bus.start;
    hl[cyc] = bus.btn_l;
    hr[cyc] = bus.btn_r;
    if (rst) begin
      last_rst  = cyc;
      m_mode    = 0;
      m_pos     = 0;
      m_next_ok = 0;
      m_wcnt    = 0;
      m_wingame = 1'b0;
    end else begin
      ps = pressed(0);
      pl = pressed(1);
      pr = pressed(2);
      m_wingame = 1'b0;
      if (m_mode == 0) begin
        if (ps) m_mode = 1;
      end else if (m_mode == 1) begin
        if ((pl != pr) && cyc >= m_next_ok) begin
          m_pos     = m_pos + (pr ? 1 : -1);
          m_next_ok = cyc + PRESS_GAP;
          if (m_pos == 3 || m_pos == -3) begin
            m_mode    = 2;
            m_wcnt    = 0;
            m_wingame = 1'b1;
          end
        end
      end else if (bus.slowen) begin
        m_wcnt++;
        if (m_wcnt == WIN_TICKS) begin
          m_mode = 0;
          m_pos  = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    n_vec++; if (bus.state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", bus.state); end
    n_vec++; if (bus.score !== 7'b0001000) begin n_err++; $display("FAIL reset_score: got %b want 0001000", bus.score); end
    n_vec++; if (bus.led_out !== 7'b0001000) begin n_err++; $display("FAIL reset_led: got %b want 0001000", bus.led_out); end
    n_vec++; if (bus.wingame !== 1'b0 || bus.game_over !== 1'b0) begin n_err++; $display("FAIL reset_flags: got wingame=%b game_over=%b want 0 0", bus.wingame, bus.game_over); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_start;
    bus.start = 1'b1;
    tick(3);
    n_vec++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL start_state: got %b want 01", bus.state); end
    n_vec++; if (bus.score !== 7'b0001000 || bus.led_out !== 7'b0001000) begin n_err++; $display("FAIL start_display: got score=%b led=%b want 0001000", bus.score, bus.led_out); end
    bus.start = 1'b0;
    tick(1);
  endtask

  task automatic test_win_sequence;
    logic [6:0] want [3] = '{7'b0000100, 7'b0000010, 7'b0000111};
    logic [6:0] vl;
    for (int i = 0; i < 3; i++) begin
      bus.btn_r = 1'b1;
      tick(3);
      n_vec++; if (bus.score !== want[i]) begin n_err++; $display("FAIL win_step%0d_score: got %b want %b", i, bus.score, want[i]); end
      n_vec++; if (bus.wingame !== (i == 2)) begin n_err++; $display("FAIL win_step%0d_wingame: got %b want %b", i, bus.wingame, (i == 2)); end
      bus.btn_r = 1'b0;
      tick(1);
      n_vec++; if (bus.wingame !== 1'b0) begin n_err++; $display("FAIL win_step%0d_pulse_width: got %b want 0", i, bus.wingame); end
      if (i < 2) tick(6);
    end
    n_vec++; if (bus.state !== 2'b10 || bus.game_over !== 1'b1) begin n_err++; $display("FAIL win_state: got state=%b game_over=%b want 10 1", bus.state, bus.game_over); end
    for (int j = 0; j < 4; j++) begin
      vl = 7'($urandom);
      bus.victory_led = vl;
      #1;
      n_vec++; if (bus.led_out !== vl) begin n_err++; $display("FAIL win_led_mux: got %b want %b", bus.led_out, vl); end
      tick(1);
    end
  endtask

  task automatic test_win_hold;
    bus.start = 1'b1;
    bus.btn_l = 1'b1;
    bus.btn_r = 1'b1;
    tick(2);
    for (int t = 0; t < 3; t++) begin
      bus.slowen = 1'b1;
      tick(1);
      bus.slowen = 1'b0;
      if (t < 2) begin
        n_vec++; if (bus.state !== 2'b10 || bus.score !== 7'b0000111) begin n_err++; $display("FAIL win_hold%0d: got state=%b score=%b want 10 0000111", t, bus.state, bus.score); end
        tick(2);
      end
    end
    n_vec++; if (bus.state !== 2'b00) begin n_err++; $display("FAIL win_exit_state: got %b want 00", bus.state); end
    n_vec++; if (bus.score !== 7'b0001000 || bus.game_over !== 1'b0) begin n_err++; $display("FAIL win_exit_display: got score=%b game_over=%b want 0001000 0", bus.score, bus.game_over); end
    bus.start = 1'b0;
    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
    tick(4);
    n_vec++; if (bus.state !== 2'b00) begin n_err++; $display("FAIL win_held_start_ignored: got %b want 00", bus.state); end
  endtask

  task automatic test_gap_drop;
    bus.start = 1'b1;
    tick(3);
    n_vec++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL gap_enter_play: got %b want 01", bus.state); end
    bus.start = 1'b0;
    tick(2);
    bus.btn_r = 1'b1;
    tick(2);
    bus.btn_r = 1'b0;
    bus.btn_l = 1'b1;
    tick(4);
    n_vec++; if (bus.score !== 7'b0000100) begin n_err++; $display("FAIL gap_left_dropped: got %b want 0000100", bus.score); end
    bus.btn_l = 1'b0;
    tick(3);
    bus.btn_l = 1'b1;
    tick(3);
    n_vec++; if (bus.score !== 7'b0001000) begin n_err++; $display("FAIL gap_left_after: got %b want 0001000", bus.score); end
    bus.btn_l = 1'b0;
    tick(5);
  endtask

  task automatic test_simultaneous;
    bus.btn_l = 1'b1;
    bus.btn_r = 1'b1;
    tick(1);
    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
    tick(1);
    bus.btn_r = 1'b1;
    tick(1);
    n_vec++; if (bus.score !== 7'b0001000) begin n_err++; $display("FAIL simul_both_dropped: got %b want 0001000", bus.score); end
    tick(2);
    n_vec++; if (bus.score !== 7'b0000100) begin n_err++; $display("FAIL simul_gap_clear: got %b want 0000100", bus.score); end
    bus.btn_r = 1'b0;
    tick(5);
  endtask

  task automatic test_reset_midplay;
    logic [6:0] want [3] = '{7'b0001000, 7'b0010000, 7'b0100000};
    for (int i = 0; i < 3; i++) begin
      bus.btn_l = 1'b1;
      tick(3);
      n_vec++; if (bus.score !== want[i]) begin n_err++; $display("FAIL midplay_step%0d: got %b want %b", i, bus.score, want[i]); end
      if (i < 2) begin
        bus.btn_l = 1'b0;
        tick(5);
      end
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_vec++; if (bus.state !== 2'b00 || bus.score !== 7'b0001000) begin n_err++; $display("FAIL midplay_reset: got state=%b score=%b want 00 0001000", bus.state, bus.score); end
    n_vec++; if (bus.wingame !== 1'b0 || bus.game_over !== 1'b0) begin n_err++; $display("FAIL midplay_reset_flags: got wingame=%b game_over=%b want 0 0", bus.wingame, bus.game_over); end
    tick(6);
    n_vec++; if (bus.state !== 2'b00 || bus.score !== 7'b0001000) begin n_err++; $display("FAIL midplay_held_button: got state=%b score=%b want 00 0001000", bus.state, bus.score); end
    bus.btn_l = 1'b0;
    tick(2);
  endtask

  task automatic test_random(input int n);
    logic [6:0] exp_score;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 5) == 0)  bus.btn_l = ~bus.btn_l;
      if ($urandom_range(0, 5) == 0)  bus.btn_r = ~bus.btn_r;
      if ($urandom_range(0, 11) == 0) bus.start = ~bus.start;
      bus.slowen = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick(1);
      bus.victory_led = 7'($urandom);
      #1;
      exp_score = score_tbl[m_pos + 3];
      n_vec++; if (bus.state !== 2'(m_mode)) begin n_err++; $display("FAIL rand_state @%0d: got %b want %b", cyc, bus.state, 2'(m_mode)); end
      n_vec++; if (bus.score !== exp_score) begin n_err++; $display("FAIL rand_score @%0d: got %b want %b", cyc, bus.score, exp_score); end
      n_vec++; if (bus.wingame !== m_wingame) begin n_err++; $display("FAIL rand_wingame @%0d: got %b want %b", cyc, bus.wingame, m_wingame); end
      n_vec++; if (bus.game_over !== (m_mode == 2)) begin n_err++; $display("FAIL rand_game_over @%0d: got %b want %b", cyc, bus.game_over, (m_mode == 2)); end
      n_vec++; if (bus.led_out !== ((m_mode == 2) ? bus.victory_led : exp_score)) begin n_err++; $display("FAIL rand_led @%0d: got %b want %b", cyc, bus.led_out, (m_mode == 2) ? bus.victory_led : exp_score); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.slowen      = 1'b0;
    bus.start       = 1'b0;
    bus.btn_l       = 1'b0;
    bus.btn_r       = 1'b0;
    bus.victory_led = 7'b0;
    test_reset();
    test_start();
    test_win_sequence();
    test_win_hold();
    test_gap_drop();
    test_simultaneous();
    test_reset_midplay();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
